// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm block family: state encodings and default widths.
package pwm_pkg;

    localparam int unsigned N_DEF      = 4;
    localparam int unsigned RATE_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : pwm_pkg

// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel for the ramp controller: target duty and rate over valid/ready.
interface pwm_ramp_ctrl_if
    import pwm_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned RATE_W = RATE_W_DEF
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [N-1:0]      cmd_target;
    logic [RATE_W-1:0] cmd_rate;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_rate,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_rate,
        output cmd_ready
    );

endinterface : pwm_ramp_ctrl_if

// File: rtl/pwm_rate_div.sv
// Period divider: counts period ticks between duty steps, reloadable from the FSM.
module pwm_rate_div
    import pwm_pkg::*;
#(
    parameter int unsigned RATE_W = RATE_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              load,
    input  logic [RATE_W-1:0] load_val,
    input  logic              tick_en,
    output logic              cnt_zero_c
);

    logic [RATE_W-1:0] rate_cnt_q;
    logic [RATE_W-1:0] rate_cnt_d;

    // Load has priority so a step can reload on the same tick that hit zero.
    always_comb begin
        rate_cnt_d = rate_cnt_q;
        if (load) begin
            rate_cnt_d = load_val;
        end else if (tick_en && (rate_cnt_q != '0)) begin
            rate_cnt_d = rate_cnt_q - RATE_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rate_cnt_q <= '0;
        end else begin
            rate_cnt_q <= rate_cnt_d;
        end
    end

    assign cnt_zero_c = (rate_cnt_q == '0);

endmodule : pwm_rate_div

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: walks duty_out one LSB per (rate+1) PWM periods toward a target.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned RATE_W = RATE_W_DEF
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                period_tick,
    input  logic                abort,
    pwm_ramp_ctrl_if.slave      cmd,
    output logic [N-1:0]        duty_out,
    output logic                busy,
    output logic                done
);

    state_e            state_q,     state_d;
    logic [N-1:0]      duty_q,      duty_d;
    logic [N-1:0]      target_q,    target_d;
    logic [RATE_W-1:0] rate_q,      rate_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic              accept_c;
    logic              tick_en_c;
    logic              step_c;
    logic              cnt_zero_c;
    logic              div_load_c;
    logic [RATE_W-1:0] div_load_val_c;
    logic [N-1:0]      duty_next_c;

    // Handshake and tick qualification; abort suppresses any tick in the same cycle.
    always_comb begin
        accept_c       = cmd.cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
        tick_en_c      = (state_q == ST_RAMP) && !abort && period_tick;
        step_c         = tick_en_c && cnt_zero_c;
        div_load_c     = accept_c || step_c;
        div_load_val_c = accept_c ? cmd.cmd_rate : rate_q;
        // Compare-and-step: never wraps, direction picked by magnitude.
        duty_next_c    = (duty_q < target_q) ? (duty_q + N'(1)) : (duty_q - N'(1));
    end

    pwm_rate_div #(
        .RATE_W (RATE_W)
    ) u_rate_div (
        .clk_in     (clk_in),
        .rst        (rst),
        .load       (div_load_c),
        .load_val   (div_load_val_c),
        .tick_en    (tick_en_c),
        .cnt_zero_c (cnt_zero_c)
    );

    // Next-state, duty stepping and registered-output decode.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        rate_d   = rate_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    target_d = cmd.cmd_target;
                    rate_d   = cmd.cmd_rate;
                    state_d  = (cmd.cmd_target == duty_q) ? ST_DONE : ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (step_c) begin
                    duty_d = duty_next_c;
                    if (duty_next_c == target_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready/busy follow the upcoming state; done trails the DONE state by one cycle.
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_RAMP);
        done_d      = (state_q == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            duty_q      <= '0;
            target_q    <= '0;
            rate_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            rate_q      <= rate_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign duty_out      = duty_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule : pwm_ramp_ctrl

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with a queue of expected duty values per tick.
module tb_pwm_ramp_ctrl;

    localparam int unsigned N      = 4;
    localparam int unsigned RATE_W = 8;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic         period_tick = 1'b0;
    logic         abort  = 1'b0;
    logic [N-1:0] duty_out;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q[$];

    pwm_ramp_ctrl_if #(.N(N), .RATE_W(RATE_W)) cif ();

    pwm_ramp_ctrl #(.N(N), .RATE_W(RATE_W)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .period_tick (period_tick),
        .abort       (abort),
        .cmd         (cif),
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clk1();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a command and hold valid until the accepting edge.
    task automatic send_cmd(input logic [N-1:0] tgt, input logic [RATE_W-1:0] rate);
        int waited;
        waited = 0;
        cif.cmd_target = tgt;
        cif.cmd_rate   = rate;
        cif.cmd_valid  = 1'b1;
        while ((cif.cmd_ready !== 1'b1) && (waited < 50)) begin
            clk1();
            waited++;
        end
        chk("cmd_ready_wait", 32'(waited < 50), 32'd1);
        clk1();
        cif.cmd_valid = 1'b0;
    endtask

    // Idle for gap cycles, pulse period_tick, then pop and compare the duty.
    task automatic do_tick(input string tag, input int gap);
        repeat (gap) clk1();
        period_tick = 1'b1;
        clk1();
        period_tick = 1'b0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0d expected=none", tag, duty_out);
        end else begin
            chk(tag, 32'(duty_out), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        cif.cmd_valid  = 1'b0;
        cif.cmd_target = '0;
        cif.cmd_rate   = '0;

        // Power-on reset
        #2 rst = 1'b0;
        clk1();
        clk1();
        chk("rst_duty",  32'(duty_out),      32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_done",  32'(done),          32'd0);
        chk("rst_ready", 32'(cif.cmd_ready), 32'd1);
        rst = 1'b1;
        clk1();

        // Up-ramp 0 -> 5, rate 0
        send_cmd(4'd5, 8'd0);
        chk("up_ready_drop", 32'(cif.cmd_ready), 32'd0);
        chk("up_busy",       32'(busy),          32'd1);
        chk("up_duty_start", 32'(duty_out),      32'd0);
        for (int i = 1; i <= 5; i++) exp_q.push_back(N'(i));
        for (int i = 0; i < 5; i++) do_tick("up_duty", 2);
        chk("up_done_early", 32'(done), 32'd0);
        clk1();
        chk("up_done",      32'(done),          32'd1);
        chk("up_ready_ret", 32'(cif.cmd_ready), 32'd1);
        chk("up_busy_end",  32'(busy),          32'd0);
        clk1();
        chk("up_done_once", 32'(done), 32'd0);

        // Climb to 12, then down-ramp to 9 at rate 2
        send_cmd(4'd12, 8'd0);
        for (int i = 6; i <= 12; i++) exp_q.push_back(N'(i));
        for (int i = 0; i < 7; i++) do_tick("to12_duty", 1);
        clk1();
        clk1();
        send_cmd(4'd9, 8'd2);
        exp_q.push_back(4'd12); exp_q.push_back(4'd12); exp_q.push_back(4'd11);
        exp_q.push_back(4'd11); exp_q.push_back(4'd11); exp_q.push_back(4'd10);
        exp_q.push_back(4'd10); exp_q.push_back(4'd10); exp_q.push_back(4'd9);
        for (int i = 0; i < 9; i++) do_tick("down_duty", 1);
        chk("down_done_early", 32'(done), 32'd0);
        clk1();
        chk("down_done", 32'(done),     32'd1);
        chk("down_duty", 32'(duty_out), 32'd9);

        // Null command: reach 7, then request 7 again
        send_cmd(4'd7, 8'd0);
        exp_q.push_back(4'd8); exp_q.push_back(4'd7);
        do_tick("to7_duty", 1);
        do_tick("to7_duty", 1);
        clk1();
        clk1();
        send_cmd(4'd7, 8'd3);
        chk("null_busy",  32'(busy),          32'd0);
        chk("null_ready", 32'(cif.cmd_ready), 32'd0);
        chk("null_done0", 32'(done),          32'd0);
        clk1();
        chk("null_done",  32'(done),          32'd1);
        chk("null_duty",  32'(duty_out),      32'd7);
        chk("null_ready_ret", 32'(cif.cmd_ready), 32'd1);
        clk1();
        chk("null_done_once", 32'(done), 32'd0);

        // Reset in the middle of a down-ramp
        send_cmd(4'd0, 8'd0);
        exp_q.push_back(4'd6); exp_q.push_back(4'd5);
        do_tick("prerst_duty", 1);
        do_tick("prerst_duty", 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_duty",  32'(duty_out),      32'd0);
        chk("mid_rst_busy",  32'(busy),          32'd0);
        chk("mid_rst_done",  32'(done),          32'd0);
        chk("mid_rst_ready", 32'(cif.cmd_ready), 32'd1);
        period_tick = 1'b1;
        clk1();
        clk1();
        period_tick = 1'b0;
        chk("rst_hold_duty", 32'(duty_out), 32'd0);
        chk("rst_hold_busy", 32'(busy),     32'd0);
        rst = 1'b1;
        clk1();

        // Abort on the 4th tick of a 0 -> 15 ramp
        send_cmd(4'd15, 8'd0);
        for (int i = 1; i <= 3; i++) exp_q.push_back(N'(i));
        for (int i = 0; i < 3; i++) do_tick("abort_duty", 1);
        clk1();
        abort       = 1'b1;
        period_tick = 1'b1;
        clk1();
        abort       = 1'b0;
        period_tick = 1'b0;
        chk("abort_freeze", 32'(duty_out),      32'd3);
        chk("abort_ready",  32'(cif.cmd_ready), 32'd1);
        chk("abort_busy",   32'(busy),          32'd0);
        chk("abort_done0",  32'(done),          32'd0);
        clk1();
        chk("abort_done1",  32'(done),          32'd0);
        clk1();
        chk("abort_hold",   32'(duty_out),      32'd3);

        // Handshake: valid held through a ramp, second command only after DONE
        cif.cmd_valid  = 1'b1;
        cif.cmd_target = 4'd5;
        cif.cmd_rate   = 8'd0;
        clk1();
        cif.cmd_target = 4'd1;
        chk("hs_ready_drop", 32'(cif.cmd_ready), 32'd0);
        exp_q.push_back(4'd4); exp_q.push_back(4'd5);
        do_tick("hs_first_duty", 1);
        do_tick("hs_first_duty", 1);
        chk("hs_ready_in_done", 32'(cif.cmd_ready), 32'd0);
        clk1();
        chk("hs_ready_idle", 32'(cif.cmd_ready), 32'd1);
        chk("hs_done",       32'(done),          32'd1);
        clk1();
        cif.cmd_valid = 1'b0;
        chk("hs_second_acc", 32'(cif.cmd_ready), 32'd0);
        chk("hs_second_busy", 32'(busy),         32'd1);
        for (int i = 4; i >= 1; i--) exp_q.push_back(N'(i));
        for (int i = 0; i < 4; i++) do_tick("hs_second_duty", 1);
        clk1();
        chk("hs_second_done", 32'(done), 32'd1);

        // Full-scale climb to 15 and back to 0 without wrap
        send_cmd(4'd15, 8'd0);
        for (int i = 2; i <= 15; i++) exp_q.push_back(N'(i));
        for (int i = 0; i < 14; i++) do_tick("full_up_duty", 0);
        clk1();
        chk("full_up_done", 32'(done), 32'd1);
        send_cmd(4'd0, 8'd0);
        for (int i = 14; i >= 0; i--) exp_q.push_back(N'(i));
        for (int i = 0; i < 15; i++) do_tick("full_dn_duty", 0);
        clk1();
        chk("full_dn_done", 32'(done),     32'd1);
        do_tick("idle_tick", 1);
        chk("full_dn_hold", 32'(duty_out), 32'd0);
        chk("sb_drained",   32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // The idle_tick above pops nothing unless one is pushed; keep it balanced.
    initial begin
        wait (cif.cmd_rate == 8'd0 && duty_out == 4'd14 && busy == 1'b1 && cif.cmd_target == 4'd0);
        exp_q.push_back(4'd0);
    end

endmodule : tb_pwm_ramp_ctrl
